// File: rtl/nn_pkg.sv
// Shared types and default widths for the nn_layer_* blocks.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 16;
  localparam int NN_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/nn_beat_counter.sv
// Up-counter with synchronous clear-to-zero load, enable, and a terminal-count
// flag. The count saturates at the terminal value instead of wrapping.
module nn_beat_counter #(
  parameter int WIDTH  = 10,
  parameter int TC_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(TC_VAL);

  logic [WIDTH-1:0] count_d, count_q;

  // Load wins over enable; once at terminal count the value holds.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && (count_q != TC)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == TC);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequences one fully-connected layer pass: clear accumulators, latch bias,
// stream NUM_INPUTS activation/weight beats, wait for the array result.
//
//   state  | meaning
//   IDLE   | waiting for start
//   CLEAR  | accumulator clear + bias read (one cycle)
//   STREAM | issuing reads, one beat per cycle unless held
//   WAIT   | no reads; wait for lyr_valid_out or timeout
//   DONE   | one-cycle completion pulse
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_WIDTH = NN_ADDR_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    hold,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic                    in_rd_en,
  output logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_rdata,
  output logic                    w_rd_en,
  output logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   w_rdata,
  output logic                    bias_rd_en,
  input  logic [2*DATA_WIDTH-1:0] bias_rdata,
  output logic                    lyr_clear,
  output logic [DATA_WIDTH-1:0]   lyr_in,
  output logic [DATA_WIDTH-1:0]   lyr_weight,
  output logic [2*DATA_WIDTH-1:0] lyr_bias,
  output logic                    lyr_in_valid,
  input  logic                    lyr_valid_out
);

  localparam int TO_WIDTH = $clog2(TIMEOUT) + 1;

  seq_state_t state_d, state_q;

  logic busy_d, busy_q;
  logic done_d, done_q;
  logic timeout_err_d, timeout_err_q;
  logic rd_en_d, rd_en_q;
  logic clear_d, clear_q;
  logic in_valid_d, in_valid_q;
  logic [2*DATA_WIDTH-1:0] bias_d, bias_q;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  idx_tc;
  logic [TO_WIDTH-1:0]   to_count_unused;
  logic                  to_tc;

  // Beat index: zeroed when a pass is accepted, advances only on an issued read.
  nn_beat_counter #(
    .WIDTH  (ADDR_WIDTH),
    .TC_VAL (NUM_INPUTS - 1)
  ) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst),
    .load  (state_d == CLEAR),
    .en    ((state_q == STREAM) && rd_en_q),
    .count (idx),
    .tc    (idx_tc)
  );

  // WAIT-cycle counter: held at zero outside WAIT so every entry starts fresh.
  nn_beat_counter #(
    .WIDTH  (TO_WIDTH),
    .TC_VAL (TIMEOUT - 1)
  ) u_to_cnt (
    .clk   (clk),
    .rst_n (rst),
    .load  (state_q != WAIT),
    .en    (state_q == WAIT),
    .count (to_count_unused),
    .tc    (to_tc)
  );

  // Next-state and sticky timeout flag; a result in the last WAIT cycle wins.
  always_comb begin
    state_d       = state_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR:  state_d = STREAM;
      STREAM: if (rd_en_q && idx_tc) state_d = WAIT;
      WAIT: begin
        if (lyr_valid_out) begin
          state_d = DONE;
        end else if (to_tc) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == CLEAR) timeout_err_d = 1'b0;
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    clear_d    = (state_d == CLEAR);
    rd_en_d    = (state_d == STREAM) && !hold;
    in_valid_d = rd_en_q;
    bias_d     = (state_q == CLEAR) ? bias_rdata : bias_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rd_en_q       <= 1'b0;
      clear_q       <= 1'b0;
      in_valid_q    <= 1'b0;
      bias_q        <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      rd_en_q       <= rd_en_d;
      clear_q       <= clear_d;
      in_valid_q    <= in_valid_d;
      bias_q        <= bias_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;
  assign in_rd_en     = rd_en_q;
  assign w_rd_en      = rd_en_q;
  assign in_addr      = idx;
  assign w_addr       = idx;
  assign bias_rd_en   = clear_q;
  assign lyr_clear    = clear_q;
  assign lyr_in_valid = in_valid_q;
  assign lyr_bias     = bias_q;
  assign lyr_in       = in_rdata;
  assign lyr_weight   = w_rdata;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer. Each pass is planned up front as a timeline:
// cycle k is the interval after clock edge k-1, start is sampled at edge 0,
// the hold value present at the edge opening a cycle governs that cycle's
// strobe, and lyr_valid_out present during cycle k is sampled at its closing
// edge. Expected outputs for every cycle follow from that plan.
module tb_nn_layer_sequencer;

  localparam int NUM_IN = 4;
  localparam int TMO    = 8;
  localparam int DW     = 16;
  localparam int AW     = 10;
  localparam int MAXC   = 64;

  logic clk, rst, start, hold;
  logic busy, done, timeout_err;
  logic in_rd_en, w_rd_en, bias_rd_en, lyr_clear, lyr_in_valid, lyr_valid_out;
  logic [AW-1:0]   in_addr, w_addr;
  logic [DW-1:0]   in_rdata, w_rdata, lyr_in, lyr_weight;
  logic [2*DW-1:0] bias_rdata, lyr_bias;

  nn_layer_sequencer #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NUM_IN),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .hold          (hold),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .in_rd_en      (in_rd_en),
    .in_addr       (in_addr),
    .in_rdata      (in_rdata),
    .w_rd_en       (w_rd_en),
    .w_addr        (w_addr),
    .w_rdata       (w_rdata),
    .bias_rd_en    (bias_rd_en),
    .bias_rdata    (bias_rdata),
    .lyr_clear     (lyr_clear),
    .lyr_in        (lyr_in),
    .lyr_weight    (lyr_weight),
    .lyr_bias      (lyr_bias),
    .lyr_in_valid  (lyr_in_valid),
    .lyr_valid_out (lyr_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem_in [NUM_IN];
  logic [DW-1:0] mem_w  [NUM_IN];

  // Memories with one-cycle read latency; junk data when not read.
  always @(posedge clk) begin
    in_rdata <= (in_rd_en && in_addr < NUM_IN) ? mem_in[in_addr[1:0]] : DW'($urandom);
    w_rdata  <= (w_rd_en && w_addr < NUM_IN) ? mem_w[w_addr[1:0]] : DW'($urandom);
  end

  int n_checks = 0;
  int n_err    = 0;

  bit          e_busy, e_done, e_clear, e_rd, e_stream, e_ival, e_terr;
  int          e_addr, e_beat;
  logic [31:0] e_bias;
  bit          prev_terr;
  logic [31:0] prev_bias;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("lyr_clear", lyr_clear, e_clear);
    chk("bias_rd_en", bias_rd_en, e_clear);
    chk("in_rd_en", in_rd_en, e_rd);
    chk("w_rd_en", w_rd_en, e_rd);
    chk("lyr_in_valid", lyr_in_valid, e_ival);
    chk("timeout_err", timeout_err, e_terr);
    chk("lyr_bias", lyr_bias, e_bias);
    if (e_stream) begin
      chk("in_addr", in_addr, e_addr);
      chk("w_addr", w_addr, e_addr);
    end
    if (e_ival) begin
      chk("lyr_in", lyr_in, mem_in[e_beat]);
      chk("lyr_weight", lyr_weight, mem_w[e_beat]);
    end
  endtask

  // hold_mode: 0 none, 1 held in cycles 3-4, 2 random.
  // vo_w: WAIT cycle (1-based) carrying lyr_valid_out, 0 = never.
  task automatic run_pass(input int hold_mode, input int vo_w, input logic [31:0] bias,
                          input bit noise, output int l_out, output int d_out, output bit t_out);
    bit h [MAXC];
    bit v [MAXC];
    bit s [MAXC];
    bit iss [MAXC];
    int bidx [MAXC];
    int abef [MAXC];
    int issued, l, d;
    bit tflag;
    for (int c = 0; c < MAXC; c++) begin
      case (hold_mode)
        1:       h[c] = (c == 3 || c == 4);
        2:       h[c] = (c < 40) && ($urandom_range(0, 99) < 35);
        default: h[c] = 1'b0;
      endcase
      v[c] = 0; s[c] = 0; iss[c] = 0; bidx[c] = 0; abef[c] = 0;
    end
    issued = 0;
    l = 0;
    for (int c = 2; c < MAXC && issued < NUM_IN; c++) begin
      abef[c] = issued;
      if (!h[c]) begin
        iss[c]  = 1;
        bidx[c] = issued;
        issued++;
        if (issued == NUM_IN) l = c;
      end
    end
    if (vo_w > 0) begin
      v[l + vo_w] = 1;
      d = l + vo_w + 1;
      tflag = 0;
    end else begin
      d = l + TMO + 1;
      tflag = 1;
    end
    if (noise) begin
      for (int c = 1; c <= l; c++) v[c] = $urandom_range(0, 1);
      v[d] = $urandom_range(0, 1);
      for (int c = 1; c <= d; c++) s[c] = $urandom_range(0, 1);
    end
    for (int c = 0; c <= d; c++) begin
      e_busy   = (c >= 1);
      e_done   = (c == d);
      e_clear  = (c == 1);
      e_rd     = iss[c];
      e_stream = (c >= 2) && (c <= l);
      e_addr   = abef[c];
      e_ival   = (c >= 1) ? iss[c-1] : 1'b0;
      e_beat   = (c >= 1) ? bidx[c-1] : 0;
      e_terr   = (c == 0) ? prev_terr : ((c == d) ? tflag : 1'b0);
      e_bias   = (c >= 2) ? bias : prev_bias;
      start         = (c == 0) | s[c];
      hold          = h[c+1];
      lyr_valid_out = v[c];
      bias_rdata    = (c == 1) ? bias : $urandom;
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
    end
    prev_terr = tflag;
    prev_bias = bias;
    l_out = l;
    d_out = d;
    t_out = tflag;
  endtask

  int pl, pd;
  bit pt;

  initial begin
    for (int i = 0; i < NUM_IN; i++) begin
      mem_in[i] = DW'($urandom);
      mem_w[i]  = DW'($urandom);
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0; lyr_valid_out = 1'b0; bias_rdata = '0;
    prev_terr = 1'b0;
    prev_bias = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_rd", in_rd_en | w_rd_en | bias_rd_en, 0);
    chk("rst_clear", lyr_clear, 0);
    chk("rst_ival", lyr_in_valid, 0);
    chk("rst_addr", {in_addr, w_addr}, 0);
    chk("rst_bias", lyr_bias, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Plain pass, result two cycles into WAIT.
    run_pass(0, 2, 32'h0001_2345, 0, pl, pd, pt);
    chk("p1_last_beat_cycle", pl, 5);
    chk("p1_done_cycle", pd, 8);
    chk("p1_timeout", pt, 0);

    // Hold in cycles 3-4 pushes everything two cycles later.
    run_pass(1, 2, 32'hCAFE_0001, 0, pl, pd, pt);
    chk("p2_last_beat_cycle", pl, 7);
    chk("p2_done_cycle", pd, 10);

    // No result: timeout after eight WAIT cycles.
    run_pass(0, 0, 32'h1234_5678, 0, pl, pd, pt);
    chk("p3_done_cycle", pd, 14);
    chk("p3_timeout", pt, 1);

    // Next pass clears the flag in CLEAR; start/result noise while busy.
    run_pass(0, 3, 32'h0BAD_F00D, 1, pl, pd, pt);
    chk("p4_done_cycle", pd, 9);

    // Reset on the second STREAM beat.
    start = 1'b1; hold = 1'b0; lyr_valid_out = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_rd", in_rd_en, 1);
    chk("pre_rst_addr", in_addr, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd", in_rd_en | w_rd_en, 0);
    chk("mid_rst_ival", lyr_in_valid, 0);
    chk("mid_rst_addr", in_addr, 0);
    chk("mid_rst_bias", lyr_bias, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_ival", lyr_in_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    prev_terr = 1'b0;
    prev_bias = '0;
    run_pass(0, 1, 32'h5555_AAAA, 0, pl, pd, pt);

    // Randomized passes.
    for (int i = 0; i < 24; i++) begin
      run_pass((i % 4 == 0) ? 0 : 2, $urandom_range(0, TMO), $urandom, 1, pl, pd, pt);
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
